// File: rtl/relobi_pkg.sv
// Shared types and helpers for the relobi SRAM shim: channel structs, a
// 64-bit-capable SECDED code used for every protected field group, and the
// 2-of-3 majority vote applied to the triplicated handshakes.
package relobi_pkg;

  localparam int unsigned AddrWidth   = 32;
  localparam int unsigned DataWidth   = 32;
  localparam int unsigned IdWidth     = 4;
  localparam int unsigned BeWidth     = DataWidth / 8;

  // SECDED over up to 64 data bits: 7 Hamming bits plus one overall parity.
  // Narrower field groups are zero-extended; padding never contributes.
  localparam int unsigned EccDataMax  = 64;
  localparam int unsigned EccIdxWidth = 6;
  localparam int unsigned EccWidth    = 8;
  localparam int unsigned EccCodeLen  = 72;
  localparam int unsigned SramWidth   = DataWidth + EccWidth;

  typedef logic a_optional_t;
  typedef logic r_optional_t;

  // Fields covered by the A-channel check bits (wdata carries its own code).
  typedef struct packed {
    a_optional_t          a_optional;
    logic [IdWidth-1:0]   aid;
    logic [BeWidth-1:0]   be;
    logic                 we;
    logic [AddrWidth-1:0] addr;
  } a_payload_t;

  localparam int unsigned APayloadWidth = $bits(a_payload_t);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 we;
    logic [BeWidth-1:0]   be;
    logic [IdWidth-1:0]   aid;
    a_optional_t          a_optional;
    logic [SramWidth-1:0] wdata;
    logic [EccWidth-1:0]  ecc;
  } relobi_a_t;

  typedef struct packed {
    logic [SramWidth-1:0] rdata;
    logic [IdWidth-1:0]   rid;
    logic                 err;
    r_optional_t          r_optional;
    logic [EccWidth-1:0]  ecc;
  } relobi_r_t;

  // A buffered response is stored already encoded.
  typedef relobi_r_t rsp_entry_t;

  typedef struct packed {
    logic [2:0] req;
    logic [2:0] rready;
    relobi_a_t  a;
  } relobi_req_t;

  typedef struct packed {
    logic [2:0] gnt;
    logic [2:0] rvalid;
    relobi_r_t  r;
  } relobi_rsp_t;

  typedef struct packed {
    logic [EccDataMax-1:0] data;
    logic                  corrected;
    logic                  uncorrectable;
  } ecc_dec_t;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
  endfunction

  function automatic logic disagree3(input logic [2:0] v);
    return (|v) & ~(&v);
  endfunction

  // Data bit k sits at the k-th non-power-of-two codeword position (3,5,6,7,9,...);
  // the Hamming bits are the XOR of the positions of all set data bits.
  function automatic logic [EccWidth-2:0] ecc_hamming(input logic [EccDataMax-1:0] data);
    logic [EccWidth-2:0] syn;
    int unsigned         k;
    syn = '0;
    k   = 0;
    for (int unsigned pos = 3; pos < EccCodeLen; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (data[k[EccIdxWidth-1:0]]) syn = syn ^ pos[EccWidth-2:0];
        k++;
      end
    end
    return syn;
  endfunction

  function automatic logic [EccWidth-1:0] ecc_encode(input logic [EccDataMax-1:0] data);
    logic [EccWidth-2:0] ham;
    ham = ecc_hamming(data);
    return {^{data, ham}, ham};
  endfunction

  // Odd overall parity means a single flip (fixed in place); even parity with
  // a non-zero syndrome means two flips, which cannot be located.
  function automatic ecc_dec_t ecc_decode(input logic [EccDataMax-1:0] data,
                                          input logic [EccWidth-1:0]   ecc);
    ecc_dec_t            dec;
    logic [EccWidth-2:0] syn;
    logic                parity;
    int unsigned         k;
    syn               = ecc_hamming(data) ^ ecc[EccWidth-2:0];
    parity            = ^{data, ecc};
    dec.data          = data;
    dec.corrected     = parity;
    dec.uncorrectable = !parity && (syn != '0);
    k = 0;
    for (int unsigned pos = 3; pos < EccCodeLen; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (parity && (pos[EccWidth-2:0] == syn)) begin
          dec.data[k[EccIdxWidth-1:0]] = ~dec.data[k[EccIdxWidth-1:0]];
        end
        k++;
      end
    end
    return dec;
  endfunction

  function automatic logic [EccDataMax-1:0] a_payload(input relobi_a_t a);
    a_payload_t p;
    p.a_optional = a.a_optional;
    p.aid        = a.aid;
    p.be         = a.be;
    p.we         = a.we;
    p.addr       = a.addr;
    return EccDataMax'(p);
  endfunction

  function automatic logic [EccDataMax-1:0] r_payload(input relobi_r_t r);
    return EccDataMax'({r.r_optional, r.err, r.rid});
  endfunction

endpackage

// File: rtl/relobi_rsp_buf.sv
// Two-entry response FIFO. The shim bypasses it when empty, so this block
// only stores entries that could not be handed over immediately.
module relobi_rsp_buf
  import relobi_pkg::*;
#(
  parameter type entry_t = rsp_entry_t
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t slots [2];
  logic   wr_ptr;
  logic   rd_ptr;

  // Storage write on push.
  // NOTE: the data slots are deliberately left out of reset; count gates every
  // read, so stale contents are never observed and the array stays plain RAM.
  always_ff @(posedge clk_i) begin
    if (push) slots[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; push and pop together keep count.
  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = slots[rd_ptr];

endmodule

// File: rtl/relobi_sram_shim.sv
// Reliable-OBI subordinate terminating into a 1-cycle-latency SRAM. Votes
// the triplicated handshakes, SECDED-decodes the A channel, and returns
// re-encoded responses in grant order through a 2-deep fall-through buffer.
module relobi_sram_shim
  import relobi_pkg::*;
#(
  parameter bit  UseRReady = 1'b1,
  parameter type obi_req_t = relobi_req_t,
  parameter type obi_rsp_t = relobi_rsp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  obi_req_t             sbr_port_req_i,
  output obi_rsp_t             sbr_port_rsp_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [SramWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [SramWidth-1:0] sram_rdata_i,
  output logic [1:0]           fault_o
);

  logic         req_v;
  logic         rready_v;
  logic         hs_fault;
  ecc_dec_t     a_dec;
  a_payload_t   a_fields;
  logic         gnt;
  logic         rvalid;
  logic         push;
  logic         pop;
  logic [2:0]   occupancy;
  logic [1:0]   count;
  rsp_entry_t   new_entry;
  rsp_entry_t   buf_head;
  rsp_entry_t   head;

  // Per-grant context captured for the response built one cycle later.
  logic               inflight_q;
  logic               we_q;
  logic               ue_q;
  logic [IdWidth-1:0] aid_q;

  logic unused_a;
  assign unused_a = ^{a_dec.data[EccDataMax-1:APayloadWidth], a_fields.a_optional,
                      a_fields.addr[1:0]};

  // Vote handshakes, decode the A channel, and drive the SRAM in the grant cycle.
  // NOTE: every combinational output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    req_v       = maj3(sbr_port_req_i.req);
    rready_v    = UseRReady ? maj3(sbr_port_req_i.rready) : 1'b1;
    hs_fault    = disagree3(sbr_port_req_i.req) ||
                  (UseRReady && disagree3(sbr_port_req_i.rready));
    a_dec       = ecc_decode(a_payload(sbr_port_req_i.a), sbr_port_req_i.a.ecc);
    a_fields    = a_payload_t'(a_dec.data[APayloadWidth-1:0]);
    occupancy   = {1'b0, count} + {2'b00, inflight_q};
    gnt         = rst_ni && req_v && (occupancy < 3'd2);
    sram_req_o  = gnt;
    // A corrupted command is still answered, but as a read so nothing is written.
    sram_we_o   = gnt && a_fields.we && !a_dec.uncorrectable;
    sram_addr_o = {a_fields.addr[AddrWidth-1:2], 2'b00};
    sram_be_o   = a_fields.be;
    sram_wdata_o = sbr_port_req_i.a.wdata;
    fault_o     = {req_v && a_dec.uncorrectable, hs_fault || a_dec.corrected};
  end

  // Track the access issued last cycle and the context its response needs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      inflight_q <= 1'b0;
      we_q       <= 1'b0;
      ue_q       <= 1'b0;
      aid_q      <= '0;
    end else begin
      inflight_q <= gnt;
      if (gnt) begin
        we_q  <= a_fields.we;
        ue_q  <= a_dec.uncorrectable;
        aid_q <= a_fields.aid;
      end
    end
  end

  // Build the encoded response and steer it past or into the buffer.
  always_comb begin
    new_entry            = '0;
    new_entry.rdata      = we_q ? '0 : sram_rdata_i;
    new_entry.rid        = aid_q;
    new_entry.err        = ue_q;
    new_entry.r_optional = '0;
    new_entry.ecc        = ecc_encode(r_payload(new_entry));
    rvalid = (count != 2'd0) || inflight_q;
    head   = (count != 2'd0) ? buf_head : new_entry;
    push   = inflight_q && !((count == 2'd0) && rready_v);
    pop    = (count != 2'd0) && rready_v;
  end

  relobi_rsp_buf #(
    .entry_t (rsp_entry_t)
  ) u_rsp_buf (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (push),
    .push_data (new_entry),
    .pop       (pop),
    .head      (buf_head),
    .count     (count)
  );

  // Triplicate handshakes; R is zero whenever no response is offered.
  always_comb begin
    sbr_port_rsp_o        = '0;
    sbr_port_rsp_o.gnt    = {3{gnt}};
    sbr_port_rsp_o.rvalid = {3{rvalid}};
    sbr_port_rsp_o.r      = rvalid ? head : '0;
  end

endmodule

// File: tb/tb_relobi_sram_shim.sv
// Directed bench for relobi_sram_shim with a 1-cycle SRAM model and an
// independently written SECDED reference used to build stimulus and expectations.
`timescale 1ns/1ps
module tb_relobi_sram_shim;
  import relobi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  relobi_req_t req;
  relobi_rsp_t rsp;
  logic        sram_req;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [39:0] sram_wdata;
  logic [39:0] sram_rdata = '0;
  logic [3:0]  sram_be;
  logic [1:0]  fault;
  logic [39:0] mem [64];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  relobi_sram_shim dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .sbr_port_req_i (req),
    .sbr_port_rsp_o (rsp),
    .sram_req_o     (sram_req),
    .sram_we_o      (sram_we),
    .sram_addr_o    (sram_addr),
    .sram_wdata_o   (sram_wdata),
    .sram_be_o      (sram_be),
    .sram_rdata_i   (sram_rdata),
    .fault_o        (fault)
  );

  // SRAM model: byte-enabled write of the data bytes, check byte written with any write.
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr[7:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
        mem[sram_addr[7:2]][39:32] <= sram_wdata[39:32];
      end else begin
        sram_rdata <= mem[sram_addr[7:2]];
      end
    end
  end

  // Reference SECDED: lay the data into a 72-position codeword, then each
  // check bit j is the parity of every position whose index has bit j set.
  function automatic logic [7:0] ref_ecc(input logic [63:0] d);
    logic       code [72];
    logic [7:0] e;
    int         k;
    k = 0;
    for (int p = 0; p < 72; p++) code[p] = 1'b0;
    for (int p = 3; p < 72; p++) begin
      if (p != 4 && p != 8 && p != 16 && p != 32 && p != 64) begin
        code[p] = d[k[5:0]];
        k++;
      end
    end
    e = '0;
    for (int j = 0; j < 7; j++)
      for (int p = 1; p < 72; p++)
        if (((p >> j) & 1) == 1) e[j] = e[j] ^ code[p];
    e[7] = (^d) ^ (^e[6:0]);
    return e;
  endfunction

  function automatic logic [39:0] mk_word(input logic [31:0] data);
    return {ref_ecc({32'h0, data}), data};
  endfunction

  function automatic logic [7:0] r_ecc(input logic [3:0] rid, input logic err);
    return ref_ecc({58'h0, 1'b0, err, rid});
  endfunction

  function automatic relobi_a_t mk_a(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                     input logic [3:0] id, input logic [31:0] data);
    relobi_a_t a;
    a.addr       = addr;
    a.we         = we;
    a.be         = be;
    a.aid        = id;
    a.a_optional = 1'b0;
    a.wdata      = mk_word(data);
    a.ecc        = ref_ecc({22'h0, 1'b0, id, be, we, addr});
    return a;
  endfunction

  task automatic drive(input logic [2:0] v, input relobi_a_t a, input logic rr);
    req.req    = v;
    req.rready = {3{rr}};
    req.a      = a;
  endtask

  task automatic idle(input logic rr);
    drive(3'b000, mk_a(1'b0, 32'h0, 4'h0, 4'h0, 32'h0), rr);
  endtask

  task automatic next_cycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    drive(3'b111, mk_a(1'b1, 32'h0, 4'hF, 4'h0, 32'h1), 1'b1);
    next_cycle();
    #1;
    checks++; if (rsp.gnt !== 3'b000) begin failures++; $display("FAIL rst_gnt got=%b want=000", rsp.gnt); end
    checks++; if (rsp.rvalid !== 3'b000) begin failures++; $display("FAIL rst_rvalid got=%b want=000", rsp.rvalid); end
    checks++; if (rsp.r !== '0) begin failures++; $display("FAIL rst_r got=%h want=0", rsp.r); end
    checks++; if ({sram_req, sram_we} !== 2'b00) begin failures++; $display("FAIL rst_sram got=%b want=00", {sram_req, sram_we}); end
    idle(1'b1);
    rst_ni = 1'b1;
    next_cycle();
    #1;
    checks++; if (rsp.rvalid !== 3'b000) begin failures++; $display("FAIL post_rst_rvalid got=%b want=000", rsp.rvalid); end
    next_cycle();
  endtask

  task automatic test_write_read;
    drive(3'b111, mk_a(1'b1, 32'h40, 4'hF, 4'd1, 32'hDEADBEEF), 1'b1);
    #1;
    checks++; if (rsp.gnt !== 3'b111) begin failures++; $display("FAIL wr_gnt got=%b want=111", rsp.gnt); end
    checks++; if ({sram_req, sram_we} !== 2'b11) begin failures++; $display("FAIL wr_req_we got=%b want=11", {sram_req, sram_we}); end
    checks++; if (sram_addr !== 32'h40) begin failures++; $display("FAIL wr_addr got=%h want=40", sram_addr); end
    checks++; if (sram_wdata !== mk_word(32'hDEADBEEF)) begin failures++; $display("FAIL wr_wdata got=%h want=%h", sram_wdata, mk_word(32'hDEADBEEF)); end
    checks++; if (sram_be !== 4'hF) begin failures++; $display("FAIL wr_be got=%h want=f", sram_be); end
    checks++; if (fault !== 2'b00) begin failures++; $display("FAIL wr_fault got=%b want=00", fault); end
    next_cycle();
    drive(3'b111, mk_a(1'b0, 32'h40, 4'hF, 4'd2, 32'h0), 1'b1);
    #1;
    checks++; if (rsp.rvalid !== 3'b111) begin failures++; $display("FAIL wr_rsp_rvalid got=%b want=111", rsp.rvalid); end
    checks++; if ({rsp.r.rid, rsp.r.err} !== {4'd1, 1'b0}) begin failures++; $display("FAIL wr_rsp_id_err got=%h/%b want=1/0", rsp.r.rid, rsp.r.err); end
    checks++; if (rsp.r.rdata !== 40'h0) begin failures++; $display("FAIL wr_rsp_rdata got=%h want=0", rsp.r.rdata); end
    checks++; if (rsp.gnt !== 3'b111 || sram_we !== 1'b0) begin failures++; $display("FAIL rd_issue gnt=%b we=%b want=111/0", rsp.gnt, sram_we); end
    next_cycle();
    idle(1'b1);
    #1;
    checks++; if (rsp.rvalid !== 3'b111) begin failures++; $display("FAIL rd_rvalid got=%b want=111", rsp.rvalid); end
    checks++; if (rsp.r.rdata !== mk_word(32'hDEADBEEF)) begin failures++; $display("FAIL rd_rdata got=%h want=%h", rsp.r.rdata, mk_word(32'hDEADBEEF)); end
    checks++; if ({rsp.r.rid, rsp.r.err} !== {4'd2, 1'b0}) begin failures++; $display("FAIL rd_id_err got=%h/%b want=2/0", rsp.r.rid, rsp.r.err); end
    checks++; if (rsp.r.ecc !== r_ecc(4'd2, 1'b0)) begin failures++; $display("FAIL rd_r_ecc got=%h want=%h", rsp.r.ecc, r_ecc(4'd2, 1'b0)); end
    next_cycle();
    #1;
    checks++; if (rsp.rvalid !== 3'b000) begin failures++; $display("FAIL rd_done_rvalid got=%b want=000", rsp.rvalid); end
    next_cycle();
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(3'b111, mk_a(1'b0, 32'(i * 4), 4'hF, 4'(3 + i), 32'h0), 1'b1);
      else idle(1'b1);
      #1;
      checks++; if (rsp.gnt !== ((i < 3) ? 3'b111 : 3'b000)) begin failures++; $display("FAIL b2b_gnt[%0d] got=%b", i, rsp.gnt); end
      if (i > 0) begin
        checks++; if (rsp.rvalid !== 3'b111 || rsp.r.rid !== 4'(2 + i)) begin failures++; $display("FAIL b2b_rsp[%0d] rvalid=%b rid=%0d want=111/%0d", i, rsp.rvalid, rsp.r.rid, 2 + i); end
        checks++; if (rsp.r.rdata !== mk_word(32'hA000_0000 + 32'(i - 1))) begin failures++; $display("FAIL b2b_rdata[%0d] got=%h", i, rsp.r.rdata); end
      end
      next_cycle();
    end
    #1;
    checks++; if (rsp.rvalid !== 3'b000) begin failures++; $display("FAIL b2b_end_rvalid got=%b want=000", rsp.rvalid); end
    next_cycle();
  endtask

  task automatic test_backpressure;
    // Per cycle: request (id, addr), rready, expected gnt, expected head rid (0 = none).
    logic [3:0] vid  [9] = '{4'd6, 4'd7, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd9, 4'd0};
    logic       vreq [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic       vrr  [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
    logic       egnt [9] = '{1, 1, 0, 0, 0, 0, 1, 1, 0};
    logic [3:0] erid [9] = '{4'd0, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd7, 4'd8, 4'd9};
    for (int i = 0; i < 9; i++) begin
      if (vreq[i]) drive(3'b111, mk_a(1'b0, 32'(vid[i] - 4'd3) * 4 + 32'h0, 4'hF, vid[i], 32'h0), vrr[i]);
      else idle(vrr[i]);
      #1;
      checks++; if (rsp.gnt !== {3{egnt[i]}} || sram_req !== egnt[i]) begin failures++; $display("FAIL bp_gnt[%0d] gnt=%b sram_req=%b want=%b", i, rsp.gnt, sram_req, egnt[i]); end
      if (erid[i] != 4'd0) begin
        checks++; if (rsp.rvalid !== 3'b111 || rsp.r.rid !== erid[i]) begin failures++; $display("FAIL bp_rsp[%0d] rvalid=%b rid=%0d want=111/%0d", i, rsp.rvalid, rsp.r.rid, erid[i]); end
        checks++; if (rsp.r.rdata !== mk_word(32'hA000_0000 + 32'(erid[i] - 4'd3))) begin failures++; $display("FAIL bp_rdata[%0d] got=%h", i, rsp.r.rdata); end
      end else begin
        checks++; if (rsp.rvalid !== 3'b000) begin failures++; $display("FAIL bp_rvalid[%0d] got=%b want=000", i, rsp.rvalid); end
      end
      next_cycle();
    end
    #1;
    checks++; if (rsp.rvalid !== 3'b000) begin failures++; $display("FAIL bp_end_rvalid got=%b want=000", rsp.rvalid); end
    next_cycle();
  endtask

  task automatic test_push_pop;
    // Park one response, issue another, then release rready so a push and a pop
    // coincide with one entry buffered.
    drive(3'b111, mk_a(1'b0, 32'h20, 4'hF, 4'd10, 32'h0), 1'b0);
    next_cycle();
    idle(1'b0);
    next_cycle();
    drive(3'b111, mk_a(1'b0, 32'h24, 4'hF, 4'd11, 32'h0), 1'b0);
    #1;
    checks++; if (rsp.gnt !== 3'b111) begin failures++; $display("FAIL pp_gnt got=%b want=111", rsp.gnt); end
    next_cycle();
    idle(1'b1);
    #1;
    checks++; if (rsp.r.rid !== 4'd10 || rsp.r.rdata !== mk_word(32'hA000_0008)) begin failures++; $display("FAIL pp_first rid=%0d rdata=%h want=10", rsp.r.rid, rsp.r.rdata); end
    next_cycle();
    #1;
    checks++; if (rsp.rvalid !== 3'b111 || rsp.r.rid !== 4'd11 || rsp.r.rdata !== mk_word(32'hA000_0009)) begin failures++; $display("FAIL pp_second rvalid=%b rid=%0d rdata=%h want=111/11", rsp.rvalid, rsp.r.rid, rsp.r.rdata); end
    next_cycle();
    #1;
    checks++; if (rsp.rvalid !== 3'b000) begin failures++; $display("FAIL pp_end_rvalid got=%b want=000", rsp.rvalid); end
    next_cycle();
  endtask

  task automatic test_tmr_fault;
    drive(3'b101, mk_a(1'b0, 32'h40, 4'hF, 4'd12, 32'h0), 1'b1);
    #1;
    checks++; if (rsp.gnt !== 3'b111) begin failures++; $display("FAIL tmr_gnt got=%b want=111", rsp.gnt); end
    checks++; if (fault !== 2'b01) begin failures++; $display("FAIL tmr_fault got=%b want=01", fault); end
    next_cycle();
    idle(1'b1);
    #1;
    checks++; if (fault !== 2'b00) begin failures++; $display("FAIL tmr_fault_clear got=%b want=00", fault); end
    checks++; if (rsp.rvalid !== 3'b111 || rsp.r.rid !== 4'd12 || rsp.r.rdata !== mk_word(32'hDEADBEEF)) begin failures++; $display("FAIL tmr_rsp rvalid=%b rid=%0d rdata=%h", rsp.rvalid, rsp.r.rid, rsp.r.rdata); end
    next_cycle();
  endtask

  task automatic test_correctable;
    relobi_a_t a;
    a = mk_a(1'b1, 32'h44, 4'hF, 4'd13, 32'hCAFEF00D);
    a.addr[3] = ~a.addr[3];
    drive(3'b111, a, 1'b1);
    #1;
    checks++; if (fault !== 2'b01) begin failures++; $display("FAIL ce_fault got=%b want=01", fault); end
    checks++; if (sram_addr !== 32'h44 || sram_we !== 1'b1) begin failures++; $display("FAIL ce_access addr=%h we=%b want=44/1", sram_addr, sram_we); end
    next_cycle();
    drive(3'b111, mk_a(1'b0, 32'h44, 4'hF, 4'd14, 32'h0), 1'b1);
    #1;
    checks++; if (rsp.r.rid !== 4'd13 || rsp.r.err !== 1'b0) begin failures++; $display("FAIL ce_wr_rsp rid=%0d err=%b want=13/0", rsp.r.rid, rsp.r.err); end
    next_cycle();
    idle(1'b1);
    #1;
    checks++; if (rsp.r.rdata !== mk_word(32'hCAFEF00D) || rsp.r.rid !== 4'd14) begin failures++; $display("FAIL ce_rd rdata=%h rid=%0d", rsp.r.rdata, rsp.r.rid); end
    next_cycle();
  endtask

  task automatic test_uncorrectable;
    relobi_a_t a;
    a = mk_a(1'b1, 32'h40, 4'hF, 4'd15, 32'h12345678);
    a.addr[4] = ~a.addr[4];
    a.addr[5] = ~a.addr[5];
    drive(3'b111, a, 1'b1);
    #1;
    checks++; if (fault !== 2'b10) begin failures++; $display("FAIL ue_fault got=%b want=10", fault); end
    checks++; if ({rsp.gnt, sram_req, sram_we} !== 5'b11110) begin failures++; $display("FAIL ue_access gnt=%b req=%b we=%b want=111/1/0", rsp.gnt, sram_req, sram_we); end
    next_cycle();
    drive(3'b111, mk_a(1'b0, 32'h40, 4'hF, 4'd0, 32'h0), 1'b1);
    #1;
    checks++; if (rsp.rvalid !== 3'b111 || rsp.r.rid !== 4'd15 || rsp.r.err !== 1'b1) begin failures++; $display("FAIL ue_rsp rvalid=%b rid=%0d err=%b want=111/15/1", rsp.rvalid, rsp.r.rid, rsp.r.err); end
    checks++; if (rsp.r.ecc !== r_ecc(4'd15, 1'b1)) begin failures++; $display("FAIL ue_r_ecc got=%h want=%h", rsp.r.ecc, r_ecc(4'd15, 1'b1)); end
    next_cycle();
    idle(1'b1);
    #1;
    checks++; if (rsp.r.rdata !== mk_word(32'hDEADBEEF) || rsp.r.err !== 1'b0) begin failures++; $display("FAIL ue_mem_unchanged rdata=%h err=%b", rsp.r.rdata, rsp.r.err); end
    next_cycle();
  endtask

  task automatic test_reset_mid;
    drive(3'b111, mk_a(1'b0, 32'h0, 4'hF, 4'd1, 32'h0), 1'b0);
    next_cycle();
    drive(3'b111, mk_a(1'b0, 32'h4, 4'hF, 4'd2, 32'h0), 1'b0);
    next_cycle();
    idle(1'b0);
    next_cycle();
    #1;
    checks++; if (rsp.rvalid !== 3'b111 || rsp.r.rid !== 4'd1) begin failures++; $display("FAIL rm_pre rvalid=%b rid=%0d want=111/1", rsp.rvalid, rsp.r.rid); end
    rst_ni = 1'b0;
    drive(3'b111, mk_a(1'b0, 32'h8, 4'hF, 4'd4, 32'h0), 1'b0);
    next_cycle();
    #1;
    checks++; if (rsp.rvalid !== 3'b000 || rsp.gnt !== 3'b000) begin failures++; $display("FAIL rm_rst rvalid=%b gnt=%b want=000/000", rsp.rvalid, rsp.gnt); end
    rst_ni = 1'b1;
    drive(3'b111, mk_a(1'b0, 32'h40, 4'hF, 4'd3, 32'h0), 1'b1);
    #1;
    checks++; if (rsp.gnt !== 3'b111 || rsp.rvalid !== 3'b000) begin failures++; $display("FAIL rm_regnt gnt=%b rvalid=%b want=111/000", rsp.gnt, rsp.rvalid); end
    next_cycle();
    idle(1'b1);
    #1;
    checks++; if (rsp.rvalid !== 3'b111 || rsp.r.rid !== 4'd3 || rsp.r.rdata !== mk_word(32'hDEADBEEF)) begin failures++; $display("FAIL rm_rsp rvalid=%b rid=%0d rdata=%h", rsp.rvalid, rsp.r.rid, rsp.r.rdata); end
    next_cycle();
    #1;
    checks++; if (rsp.rvalid !== 3'b000) begin failures++; $display("FAIL rm_end_rvalid got=%b want=000", rsp.rvalid); end
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = mk_word(32'hA000_0000 + 32'(i));
    idle(1'b1);
    @(negedge clk);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_push_pop();
    test_tmr_fault();
    test_correctable();
    test_uncorrectable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
